// File: rtl/hd44780_status_leds.sv
// hd44780_status_leds: status indicators for the board top.
// Provides N independent LED channels. Each channel has a 2-bit mode (off / on / blink / button)
// and a PWM brightness level. The block also has a free-running heartbeat and a synchronised,
// debounced user button with a press strobe.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset (deassertion synchronised by the top)
//   i_mode       per-channel mode, channel k at [2k+1:2k]
//   i_level      per-channel brightness, channel k at [PWM_BITS*(k+1)-1:PWM_BITS*k]
//   i_button     raw button, active high, asynchronous to i_clk
//   o_led        registered LED drive, polarity per ACTIVE_LOW mask
//   o_heartbeat  registered alive indicator, high during the first half of the blink period
//   o_button     debounced button level, active high
//   o_press      one-cycle strobe after each debounced 0->1 transition
module hd44780_status_leds #(
   parameter int unsigned         CHANNELS      = 4,
   parameter int unsigned         PWM_BITS      = 3,
   parameter int unsigned         BLINK_BITS    = 25,
   parameter int unsigned         DEBOUNCE_BITS = 16,
   parameter logic [CHANNELS-1:0] ACTIVE_LOW    = '0
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [2*CHANNELS-1:0]        i_mode,
   input  logic [PWM_BITS*CHANNELS-1:0] i_level,
   input  logic                         i_button,
   output logic [CHANNELS-1:0]          o_led,
   output logic                         o_heartbeat,
   output logic                         o_button,
   output logic                         o_press
);

   localparam int unsigned MODE_BITS = 2;

   typedef enum logic [MODE_BITS-1:0] {
      MODE_OFF    = 2'b00,
      MODE_ON     = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_BUTTON = 2'b11
   } mode_e;

   logic [PWM_BITS-1:0]      pwm_ctr;
   logic [BLINK_BITS-1:0]    blink_ctr;
   logic                     blink_on_c;
   logic                     btn_s1;
   logic                     btn_s2;
   logic [DEBOUNCE_BITS-1:0] db_ctr;
   logic                     btn_prev;
   logic [CHANNELS-1:0]      bright_c;
   logic [CHANNELS-1:0]      on_c;

   // Free-running PWM and blink timebases
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pwm_ctr   <= '0;
         blink_ctr <= '0;
      end else begin
         pwm_ctr   <= pwm_ctr + PWM_BITS'(1);
         blink_ctr <= blink_ctr + BLINK_BITS'(1);
      end
   end

   assign blink_on_c = ~blink_ctr[BLINK_BITS-1];

   // Per-channel brightness gate and mode decode
   always_comb begin
      logic [PWM_BITS-1:0]  lvl;
      logic [MODE_BITS-1:0] md;
      bright_c = '0;
      on_c     = '0;
      lvl      = '0;
      md       = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         lvl = i_level[k*PWM_BITS +: PWM_BITS];
         md  = i_mode[k*MODE_BITS +: MODE_BITS];
         // Full-scale level is forced to 100% rather than (2^P-1)/2^P
         bright_c[k] = (lvl == '1) || (pwm_ctr < lvl);
         case (mode_e'(md))
            MODE_OFF:    on_c[k] = 1'b0;
            MODE_ON:     on_c[k] = bright_c[k];
            MODE_BLINK:  on_c[k] = bright_c[k] & blink_on_c;
            MODE_BUTTON: on_c[k] = bright_c[k] & o_button;
            default:     on_c[k] = 1'b0;
         endcase
      end
   end

   // Registered LED and heartbeat drive; reset leaves every LED dark
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_led       <= ACTIVE_LOW;
         o_heartbeat <= 1'b1;
      end else begin
         o_led       <= on_c ^ ACTIVE_LOW;
         o_heartbeat <= blink_on_c;
      end
   end

   // Two-flop synchroniser for the asynchronous button
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         btn_s1 <= i_button;
         btn_s2 <= btn_s1;
      end
   end

   // Debouncer: accept a new level only after it has held for 2^DEBOUNCE_BITS clocks
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         db_ctr   <= '0;
         o_button <= 1'b0;
      end else if (btn_s2 == o_button) begin
         db_ctr <= '0;
      end else if (db_ctr == '1) begin
         o_button <= btn_s2;
         db_ctr   <= '0;
      end else begin
         db_ctr <= db_ctr + DEBOUNCE_BITS'(1);
      end
   end

   // Press strobe: one cycle after the debounced level rises
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         btn_prev <= 1'b0;
         o_press  <= 1'b0;
      end else begin
         btn_prev <= o_button;
         o_press  <= o_button & ~btn_prev;
      end
   end

endmodule

// File: tb/tb_hd44780_status_leds.sv
// Testbench for hd44780_status_leds: directed scenarios plus randomized stimulus,
// every cycle compared against a behavioural model of the LED/heartbeat/button rules.
module tb_hd44780_status_leds;

   localparam int unsigned CH = 4;
   localparam int unsigned PB = 3;
   localparam int unsigned BB = 6;
   localparam int unsigned DB = 3;
   localparam logic [CH-1:0] AL = 4'b1000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    mode;
   logic [11:0]   level;
   logic          button;
   logic [CH-1:0] o_led;
   logic          o_heartbeat;
   logic          o_button;
   logic          o_press;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: edges since reset release, model debounced level and its previous value,
   // and the raw button value seen at each edge since reset release.
   int n_edge;
   bit ob;
   bit ob_q;
   bit b_hist[$];

   hd44780_status_leds #(
      .CHANNELS(CH), .PWM_BITS(PB), .BLINK_BITS(BB), .DEBOUNCE_BITS(DB), .ACTIVE_LOW(AL)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_level(level), .i_button(button),
      .o_led(o_led), .o_heartbeat(o_heartbeat), .o_button(o_button), .o_press(o_press)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      n_edge = 0;
      ob     = 1'b0;
      ob_q   = 1'b0;
      b_hist.delete();
   endtask

   // Synchronised button as seen by the debouncer at edge m: raw value from two edges earlier
   function automatic bit s2_at(input int m);
      return (m >= 3) ? b_hist[m-3] : 1'b0;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_led"},    32'(o_led),       32'(AL));
      check({tag, "_hb"},     32'(o_heartbeat), 32'd1);
      check({tag, "_button"}, 32'(o_button),    32'd0);
      check({tag, "_press"},  32'(o_press),     32'd0);
   endtask

   task automatic reset_cycle();
      @(posedge clk);
      #1;
      check_reset_vals("rst");
   endtask

   // One clock: advance model from the inputs held across this edge, then compare
   task automatic step();
      int       pwm;
      int       phase;
      int       lit_slots;
      bit       blink_on;
      bit       all_diff;
      bit       lit;
      bit [3:0] on;
      bit [1:0] md;
      bit [2:0] lv;
      bit       exp_press;
      @(posedge clk);
      n_edge++;
      b_hist.push_back(button);
      #1;
      pwm      = (n_edge - 1) % 8;
      phase    = (n_edge - 1) % 64;
      blink_on = (phase < 32);
      on       = '0;
      for (int k = 0; k < 4; k++) begin
         md        = mode[2*k +: 2];
         lv        = level[3*k +: 3];
         lit_slots = (lv == 3'd7) ? 8 : int'(lv);
         lit       = (pwm < lit_slots);
         case (md)
            2'd0:    on[k] = 1'b0;
            2'd1:    on[k] = lit;
            2'd2:    on[k] = lit & blink_on;
            default: on[k] = lit & ob;
         endcase
      end
      exp_press = ob & ~ob_q;
      ob_q      = ob;
      // Level flips once the synchronised input has disagreed for 8 consecutive edges
      all_diff = (n_edge >= 8);
      for (int j = n_edge - 7; j <= n_edge; j++)
         if (j >= 1 && s2_at(j) == ob) all_diff = 1'b0;
      if (all_diff) ob = ~ob;
      check("led",    32'(o_led),       32'(on ^ AL));
      check("hb",     32'(o_heartbeat), 32'(blink_on));
      check("button", 32'(o_button),    32'(ob));
      check("press",  32'(o_press),     32'(exp_press));
   endtask

   task automatic measure_press_latency(input string tag);
      int lat;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!o_button && lat < 40);
      check({tag, "_latency"}, 32'(lat), 32'd10);
      step();
      check({tag, "_press"}, 32'(o_press), 32'd1);
   endtask

   initial begin
      int cnt;
      int presses;
      int seg;
      int lat;
      logic [2:0] lv_tab [3];
      int         duty_tab [3];
      lv_tab   = '{3'd0, 3'd3, 3'd7};
      duty_tab = '{0, 24, 64};

      rst_n  = 1'b0;
      mode   = '0;
      level  = '0;
      button = 1'b0;
      model_reset();

      // Reset held for 5 clocks
      repeat (5) reset_cycle();
      @(negedge clk);
      rst_n = 1'b1;

      // ch0 ON at several levels; ch3 ON full scale (active-low pin stays 0)
      for (int i = 0; i < 3; i++) begin
         mode  = 8'b01_00_00_01;
         level = {3'd7, 3'd0, 3'd0, lv_tab[i]};
         cnt   = 0;
         repeat (64) begin
            step();
            cnt += int'(o_led[0]);
         end
         check("ch0_duty", 32'(cnt), 32'(duty_tab[i]));
      end

      // ch1 BLINK full scale: 32 of 64 clocks lit
      mode  = 8'b00_00_10_00;
      level = 12'b000_000_111_000;
      cnt   = 0;
      repeat (64) begin
         step();
         cnt += int'(o_led[1]);
      end
      check("ch1_blink", 32'(cnt), 32'd32);

      // Clean button rise with ch2 following the button
      mode   = 8'b00_11_00_00;
      level  = 12'b000_111_000_000;
      button = 1'b1;
      measure_press_latency("clean");
      check("ch2_on_with_press", 32'(o_led[2]), 32'd1);
      button = 1'b0;
      repeat (15) step();

      // Bouncing button must not be accepted
      presses = 0;
      cnt     = 0;
      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 0) button = ~button;
         step();
         presses += int'(o_press);
         cnt     += int'(o_button);
      end
      check("bounce_press", 32'(presses), 32'd0);
      check("bounce_level", 32'(cnt), 32'd0);
      button  = 1'b1;
      presses = 0;
      repeat (20) begin
         step();
         presses += int'(o_press);
      end
      check("hold_single_press", 32'(presses), 32'd1);

      // Asynchronous reset mid-clock with button accepted and ch0 ON
      mode  = 8'b00_00_00_01;
      level = 12'd7;
      repeat (3) step();
      check("pre_async_button", 32'(o_button), 32'd1);
      check("pre_async_led", 32'(o_led), 32'b1001);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async");
      model_reset();
      repeat (3) reset_cycle();
      @(negedge clk);
      rst_n = 1'b1;
      measure_press_latency("after_rst");

      // Randomized modes, levels and button segments
      seg = 0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(7) == 0) mode  = 8'($urandom);
         if ($urandom_range(7) == 0) level = 12'($urandom);
         if (seg == 0) begin
            button = 1'($urandom);
            seg    = $urandom_range(1, 14);
         end
         seg--;
         step();
      end

      // Occasional random reset in the middle of activity
      button = 1'b1;
      repeat (int'($urandom_range(3, 9))) step();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("rand_rst");
      model_reset();
      reset_cycle();
      @(negedge clk);
      rst_n = 1'b1;
      lat = 0;
      repeat (30) begin
         step();
         lat++;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
